idma_axis_tx: RTL and testbench
===============================

# idma_axis_tx

Write-side AXI Stream transport stage of the iDMA backend. Drains realigned bytes from the per-byte dataflow buffer (fed by the read stage), forms AXI Stream beats with per-beat strobe/keep masks and a counted `tlast`, and reports transfer completion on the write datapath response channel. Sits between the dataflow buffer and the AXI Stream subordinate port, mirroring the AXI Stream read stage on the other side of the buffer.

## Interface
- `StrbWidth`, 16: bytes per beat.
- `byte_t`, logic: byte type.
- `strb_t`, logic: `StrbWidth`-bit mask type.
- `write_req_t`, logic: AXIS request struct; fields `tvalid` and `t` (`data`, `strb`, `keep`, `last`).
- `write_rsp_t`, logic: AXIS response struct; field `tready`.
- `w_dp_req_t`, logic: fields `offset` and `tailer` ($clog2(StrbWidth) bits each), and `num_beats` (8 bits, beats minus one).
- `w_dp_rsp_t`, logic: fields `resp` (2 bits), `user`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous and active-high; this is the only clock and reset.
- `w_dp_req_i` in `w_dp_req_t`: transfer descriptor.
- `w_dp_req_valid_i` / `w_dp_req_ready_o` in/out 1: descriptor handshake.
- `w_dp_rsp_o` out `w_dp_rsp_t`: completion payload.
- `w_dp_rsp_valid_o` / `w_dp_rsp_ready_i` out/in 1: completion handshake.
- `buffer_out_i` in `byte_t[StrbWidth]`: buffer head bytes.
- `buffer_out_valid_i` in `strb_t`: per-byte buffer valid.
- `buffer_out_ready_o` out `strb_t`: per-byte pop.
- `write_req_o` out `write_req_t`: AXIS manager output.
- `write_rsp_i` in `write_rsp_t`: AXIS `tready`.

## Operation
- FSM states: IDLE, STREAM, RESP.
  - IDLE: `w_dp_req_ready_o`=1. On `w_dp_req_valid_i`, latch the descriptor, load the beat counter with `num_beats`, set the `first` flag, and go to STREAM.
  - STREAM: emit beats. After the `tlast` beat completes its AXIS handshake, go to RESP.
  - RESP: `w_dp_rsp_valid_o`=1 with `resp`='0 and `user`='0. On `w_dp_rsp_ready_i`, go to IDLE.
- Beat mask:
  - Base mask is `'1`.
  - First beat: AND with `'1 << offset`.
  - Last beat (counter==0): AND with `'1 >> (StrbWidth-tailer)`. `tailer`==0 means a full last beat.
  - `num_beats`==0: both terms apply to the single beat.
- Pop condition: `&(buffer_out_valid_i | ~mask)` and the output stage can accept a beat.
- On a pop:
  - `buffer_out_ready_o` = mask. Bytes outside the mask are never popped.
  - Load the output stage with data=`buffer_out_i`, strb=keep=mask, last=(counter==0).
  - Decrement the counter and clear `first`.
- Pops stop after the last beat is loaded. `buffer_out_ready_o`='0 in IDLE, in RESP, and in any cycle without a pop.
- Output stage is a one-entry register with spill. It may load in the same cycle it is drained.

## Timing
- Reset values: `write_req_o.tvalid`=0, `w_dp_rsp_valid_o`=0, `buffer_out_ready_o`='0, FSM=IDLE, counter=0. Because `w_dp_req_ready_o` is 1 in IDLE, it is 1 in the first cycle after reset.
- Reset mid-transfer discards the output register and the descriptor. Bytes not yet popped stay in the buffer.
- Latency: a byte popped in cycle N appears on `tvalid` in cycle N+1.
- Throughput: one beat per cycle while `tready`=1 and the buffer is ready.
- AXIS rule: once `tvalid`=1, `t` holds stable until `tready`=1. `tvalid` never drops without a handshake.
- `w_dp_rsp_valid_o` rises the cycle after the `tlast` handshake. It stays high until `w_dp_rsp_ready_i`=1.
- Only one transfer is in flight. A descriptor is not accepted during STREAM or RESP. A stalled RESP blocks the next descriptor.
- Counter width is 8 bits and counts down from `num_beats`, so a transfer is at most 256 beats.

## Structure
- Shared package `idma_axis_pkg` holds:
  - the `axis_tx_state_e` enum (IDLE/STREAM/RESP);
  - the mask function (offset, tailer, first, last) -> `strb_t`, shared with the read stage's mask logic.
- One sub-module: the output stage as common_cells `spill_register`, carrying {data, strb, keep, last}.

## Test plan
- StrbWidth=4; offset=1, tailer=3, num_beats=2; buffer always valid -> 3 beats with strb 4'b1110, 4'b1111, 4'b0111; `tlast` only on beat 3; one `w_dp_rsp` with resp=0.
- num_beats=0, offset=1, tailer=3 -> single beat with strb 4'b0110 and last=1; `buffer_out_ready_o`=4'b0110 for exactly one cycle.
- `tready` toggled 1,0,0,1 during a 4-beat transfer -> data/strb stable while `tready`=0; no beat lost or duplicated; 4 pops total.
- Buffer byte 2 invalid for 3 cycles with mask 4'b1111 -> no pop; `buffer_out_ready_o`='0; `tvalid` falls only after the pending beat handshakes.
- `w_dp_rsp_ready_i` held 0 for 5 cycles with a second descriptor pending -> `w_dp_req_ready_o`=0 throughout; second transfer starts the cycle after the response handshake.
- `rst_i` asserted mid-STREAM -> next cycle `tvalid`=0, FSM=IDLE, `w_dp_req_ready_o`=1; new transfer runs cleanly.

Source files
------------

// File: rtl/idma_axis_pkg.sv
// Shared types and helpers for the iDMA AXI Stream transport stages.
// The mask function is width-generic so the read and write stages can share it.
package idma_axis_pkg;

  localparam int unsigned StrbWidth    = 16;
  localparam int unsigned MaxStrbWidth = 64;
  localparam int unsigned OffsetWidth  = $clog2(StrbWidth);

  typedef logic [7:0]           byte_t;
  typedef logic [StrbWidth-1:0] strb_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    RESP
  } axis_tx_state_e;

  typedef struct packed {
    byte_t [StrbWidth-1:0] data;
    strb_t                 strb;
    strb_t                 keep;
    logic                  last;
  } axis_t;

  typedef struct packed {
    logic  tvalid;
    axis_t t;
  } write_req_t;

  typedef struct packed {
    logic tready;
  } write_rsp_t;

  typedef struct packed {
    logic [OffsetWidth-1:0] offset;
    logic [OffsetWidth-1:0] tailer;
    logic [7:0]             num_beats;
  } w_dp_req_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       user;
  } w_dp_rsp_t;

  // Lane i is live when inside the beat width, at/after offset on the first
  // beat, and below tailer on the last beat (tailer 0 = full last beat).
  function automatic logic [MaxStrbWidth-1:0] axis_mask(
    input int unsigned width,
    input int unsigned offset,
    input int unsigned tailer,
    input logic        first,
    input logic        last
  );
    logic [MaxStrbWidth-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxStrbWidth; i++) begin
      m[i] = (i < width) && (!first || i >= offset) && (!last || tailer == 0 || i < tailer);
    end
    return m;
  endfunction

endpackage

// File: rtl/idma_axis_tx_spill.sv
// Two-slot spill register: full throughput with a registered ready toward
// the producer; slot b only fills when the consumer stalls.
module idma_axis_tx_spill #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic a_full_q, b_full_q;
  T     a_q, b_q;
  logic a_fill, a_drain, b_fill, b_drain;

  assign a_fill  = valid_i && ready_o;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !ready_i;
  assign b_drain = b_full_q && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      if (a_fill)            a_q      <= data_i;
      if (a_fill || a_drain) a_full_q <= a_fill;
      if (b_fill)            b_q      <= a_q;
      if (b_fill || b_drain) b_full_q <= b_fill;
    end
  end

  assign ready_o = !a_full_q || !b_full_q;
  assign valid_o = a_full_q || b_full_q;
  assign data_o  = b_full_q ? b_q : a_q;

endmodule

// File: rtl/idma_axis_tx.sv
// iDMA write-side AXI Stream stage: pops realigned bytes from the dataflow
// buffer, shapes them into masked beats with a counted tlast, reports completion.
module idma_axis_tx #(
  parameter int unsigned StrbWidth = idma_axis_pkg::StrbWidth,
  parameter type write_req_t = idma_axis_pkg::write_req_t,
  parameter type write_rsp_t = idma_axis_pkg::write_rsp_t,
  parameter type w_dp_req_t  = idma_axis_pkg::w_dp_req_t,
  parameter type w_dp_rsp_t  = idma_axis_pkg::w_dp_rsp_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  w_dp_req_t                             w_dp_req_i,
  input  logic                                  w_dp_req_valid_i,
  output logic                                  w_dp_req_ready_o,
  output w_dp_rsp_t                             w_dp_rsp_o,
  output logic                                  w_dp_rsp_valid_o,
  input  logic                                  w_dp_rsp_ready_i,
  input  idma_axis_pkg::byte_t [StrbWidth-1:0]  buffer_out_i,
  input  logic                 [StrbWidth-1:0]  buffer_out_valid_i,
  output logic                 [StrbWidth-1:0]  buffer_out_ready_o,
  output write_req_t                            write_req_o,
  input  write_rsp_t                            write_rsp_i
);
  import idma_axis_pkg::*;

  localparam int unsigned OffW = $clog2(StrbWidth);

  typedef struct packed {
    byte_t [StrbWidth-1:0] data;
    logic  [StrbWidth-1:0] strb;
    logic  [StrbWidth-1:0] keep;
    logic                  last;
  } beat_t;

  axis_tx_state_e        state_q, state_d;
  logic [7:0]            cnt_q;
  logic                  first_q, loaded_q;
  logic [OffW-1:0]       off_q, tail_q;
  logic [StrbWidth-1:0]  mask;
  logic                  pop, accept, last_hs;
  logic                  stage_ready, stage_valid;
  beat_t                 beat_in, beat_out;

  assign accept = (state_q == IDLE) && w_dp_req_valid_i;
  assign mask   = StrbWidth'(axis_mask(StrbWidth, 32'(off_q), 32'(tail_q), first_q, cnt_q == 8'd0));

  // loaded_q gates further pops once the tlast beat sits in the output stage
  assign pop = (state_q == STREAM) && !loaded_q && (&(buffer_out_valid_i | ~mask)) && stage_ready;
  assign buffer_out_ready_o = pop ? mask : '0;

  assign beat_in.data = buffer_out_i;
  assign beat_in.strb = mask;
  assign beat_in.keep = mask;
  assign beat_in.last = (cnt_q == 8'd0);

  idma_axis_tx_spill #(.T(beat_t)) i_out_stage (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (pop),
    .ready_o (stage_ready),
    .data_i  (beat_in),
    .valid_o (stage_valid),
    .ready_i (write_rsp_i.tready),
    .data_o  (beat_out)
  );

  assign last_hs = stage_valid && write_rsp_i.tready && beat_out.last;

  always_comb begin
    write_req_o        = '0;
    write_req_o.tvalid = stage_valid;
    write_req_o.t.data = beat_out.data;
    write_req_o.t.strb = beat_out.strb;
    write_req_o.t.keep = beat_out.keep;
    write_req_o.t.last = beat_out.last;
  end

  always_comb begin
    state_d          = state_q;
    w_dp_req_ready_o = 1'b0;
    w_dp_rsp_valid_o = 1'b0;
    w_dp_rsp_o       = '0;
    case (state_q)
      IDLE: begin
        w_dp_req_ready_o = 1'b1;
        if (w_dp_req_valid_i) state_d = STREAM;
      end
      STREAM: if (last_hs) state_d = RESP;
      RESP: begin
        w_dp_rsp_valid_o = 1'b1;
        if (w_dp_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= 8'd0;
      first_q  <= 1'b0;
      loaded_q <= 1'b0;
      off_q    <= '0;
      tail_q   <= '0;
    end else if (accept) begin
      cnt_q    <= w_dp_req_i.num_beats;
      first_q  <= 1'b1;
      loaded_q <= 1'b0;
      off_q    <= w_dp_req_i.offset;
      tail_q   <= w_dp_req_i.tailer;
    end else if (pop) begin
      first_q <= 1'b0;
      if (cnt_q == 8'd0) loaded_q <= 1'b1;
      else               cnt_q    <= cnt_q - 8'd1;
    end
  end

endmodule

// File: tb/tb_idma_axis_tx.sv
// Directed bench for idma_axis_tx at 4 bytes per beat.
module tb_idma_axis_tx;
  import idma_axis_pkg::*;

  typedef struct packed {
    logic [3:0][7:0] data;
    logic [3:0]      strb;
    logic [3:0]      keep;
    logic            last;
  } tb_axis_t;
  typedef struct packed { logic tvalid; tb_axis_t t; } tb_wreq_t;
  typedef struct packed { logic tready; } tb_wrsp_t;
  typedef struct packed { logic [1:0] offset; logic [1:0] tailer; logic [7:0] num_beats; } tb_dpreq_t;
  typedef struct packed { logic [1:0] resp; logic user; } tb_dprsp_t;

  logic            clk = 1'b0;
  logic            rst;
  tb_dpreq_t       dp_req;
  logic            dp_req_valid, dp_req_ready;
  tb_dprsp_t       dp_rsp;
  logic            dp_rsp_valid, dp_rsp_ready;
  logic [3:0][7:0] buf_data;
  logic [3:0]      buf_valid, buf_ready;
  tb_wreq_t        wreq;
  tb_wrsp_t        wrsp;

  int n_cmp = 0;
  int n_err = 0;

  int seq = 0;
  int cyc = 0;
  int first_pop, first_beat, last_hs_cyc, rsp_first;
  logic [3:0]  pops[$];
  logic [31:0] pop_data[$];
  logic [3:0]  b_strb[$];
  logic [3:0]  b_keep[$];
  logic        b_last[$];
  logic [31:0] b_data[$];
  tb_dprsp_t   rsps[$];

  always #5 clk = ~clk;

  idma_axis_tx #(
    .StrbWidth   (4),
    .write_req_t (tb_wreq_t),
    .write_rsp_t (tb_wrsp_t),
    .w_dp_req_t  (tb_dpreq_t),
    .w_dp_rsp_t  (tb_dprsp_t)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .w_dp_req_i         (dp_req),
    .w_dp_req_valid_i   (dp_req_valid),
    .w_dp_req_ready_o   (dp_req_ready),
    .w_dp_rsp_o         (dp_rsp),
    .w_dp_rsp_valid_o   (dp_rsp_valid),
    .w_dp_rsp_ready_i   (dp_rsp_ready),
    .buffer_out_i       (buf_data),
    .buffer_out_valid_i (buf_valid),
    .buffer_out_ready_o (buf_ready),
    .write_req_o        (wreq),
    .write_rsp_i        (wrsp)
  );

  task automatic set_buf();
    for (int i = 0; i < 4; i++) buf_data[i] = 8'(seq * 4 + i);
  endtask

  // Logs handshakes seen in the settled current cycle, then advances one clock.
  task automatic step();
    logic popped;
    popped = (buf_ready != 4'b0);
    if (popped) begin
      pops.push_back(buf_ready);
      pop_data.push_back(buf_data);
      if (first_pop < 0) first_pop = cyc;
    end
    if (wreq.tvalid && wrsp.tready) begin
      b_strb.push_back(wreq.t.strb);
      b_keep.push_back(wreq.t.keep);
      b_last.push_back(wreq.t.last);
      b_data.push_back(wreq.t.data);
      if (first_beat < 0) first_beat = cyc;
      if (wreq.t.last) last_hs_cyc = cyc;
    end
    if (dp_rsp_valid && rsp_first < 0) rsp_first = cyc;
    if (dp_rsp_valid && dp_rsp_ready) rsps.push_back(dp_rsp);
    @(posedge clk);
    #1;
    cyc++;
    if (popped) begin
      seq++;
      set_buf();
    end
  endtask

  task automatic clear_log();
    pops.delete(); pop_data.delete(); b_strb.delete(); b_keep.delete();
    b_last.delete(); b_data.delete(); rsps.delete();
    first_pop = -1; first_beat = -1; last_hs_cyc = -1; rsp_first = -1;
  endtask

  task automatic start(input logic [1:0] off, input logic [1:0] tail, input logic [7:0] nb,
                       output logic acc);
    dp_req       = '{offset: off, tailer: tail, num_beats: nb};
    dp_req_valid = 1'b1;
    #1;
    acc = dp_req_ready;
    step();
    dp_req_valid = 1'b0;
  endtask

  task automatic run_until_rsp(input int max, output logic ok);
    int n0;
    n0 = rsps.size();
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      #1;
      step();
      if (rsps.size() > n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dp_req = '0; dp_req_valid = 1'b0; dp_rsp_ready = 1'b1;
    buf_valid = 4'hf; wrsp.tready = 1'b1; set_buf();
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++; if (wreq.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %0b want 0", wreq.tvalid); end
    n_cmp++; if (dp_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0b want 0", dp_rsp_valid); end
    n_cmp++; if (buf_ready !== 4'b0) begin n_err++; $display("FAIL reset_buf_ready: got %b want 0000", buf_ready); end
    n_cmp++; if (dp_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %0b want 1", dp_req_ready); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
    n_cmp++; if (dut.cnt_q !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
  endtask

  task automatic test_basic();
    logic acc, ok;
    logic [3:0] es[3] = '{4'b1110, 4'b1111, 4'b0111};
    logic       el[3] = '{1'b0, 1'b0, 1'b1};
    clear_log();
    start(2'd1, 2'd3, 8'd2, acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %0b want 1", acc); end
    run_until_rsp(30, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: no response within 30 cycles"); end
    n_cmp++; if (b_strb.size() != 3) begin n_err++; $display("FAIL basic_beats: got %0d want 3", b_strb.size()); end
    n_cmp++; if (pops.size() != 3) begin n_err++; $display("FAIL basic_pops: got %0d want 3", pops.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (b_strb[i] !== es[i]) begin n_err++; $display("FAIL basic_strb%0d: got %b want %b", i, b_strb[i], es[i]); end
      n_cmp++; if (b_keep[i] !== es[i]) begin n_err++; $display("FAIL basic_keep%0d: got %b want %b", i, b_keep[i], es[i]); end
      n_cmp++; if (b_last[i] !== el[i]) begin n_err++; $display("FAIL basic_last%0d: got %b want %b", i, b_last[i], el[i]); end
      n_cmp++; if (pops[i] !== es[i]) begin n_err++; $display("FAIL basic_pop%0d: got %b want %b", i, pops[i], es[i]); end
      n_cmp++; if (b_data[i] !== pop_data[i]) begin n_err++; $display("FAIL basic_data%0d: got %h want %h", i, b_data[i], pop_data[i]); end
    end
    n_cmp++; if (rsps.size() != 1 || rsps[0] !== 3'b000) begin n_err++; $display("FAIL basic_rsp: got n=%0d val=%b want n=1 val=000", rsps.size(), rsps[0]); end
    n_cmp++; if (first_beat - first_pop != 1) begin n_err++; $display("FAIL basic_latency: got %0d want 1", first_beat - first_pop); end
    n_cmp++; if (rsp_first - last_hs_cyc != 1) begin n_err++; $display("FAIL basic_rsp_latency: got %0d want 1", rsp_first - last_hs_cyc); end
  endtask

  task automatic test_single();
    logic acc, ok;
    clear_log();
    start(2'd1, 2'd3, 8'd0, acc);
    run_until_rsp(20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_timeout: no response within 20 cycles"); end
    n_cmp++; if (b_strb.size() != 1 || b_strb[0] !== 4'b0110 || b_last[0] !== 1'b1) begin
      n_err++; $display("FAIL single_beat: got n=%0d strb=%b last=%b want n=1 strb=0110 last=1", b_strb.size(), b_strb[0], b_last[0]); end
    n_cmp++; if (pops.size() != 1 || pops[0] !== 4'b0110) begin
      n_err++; $display("FAIL single_pop: got n=%0d mask=%b want n=1 mask=0110", pops.size(), pops[0]); end
  endtask

  task automatic test_tready_stall();
    logic acc;
    logic stalled = 1'b0;
    tb_axis_t held = '0;
    int k = -1;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_log();
    start(2'd0, 2'd0, 8'd3, acc);
    for (int i = 0; i < 40; i++) begin
      if (wreq.tvalid && k < 0) k = 0;
      wrsp.tready = (k >= 0 && k < 4) ? pat[k] : 1'b1;
      #1;
      if (stalled) begin
        n_cmp++; if (wreq.tvalid !== 1'b1 || wreq.t !== held) begin
          n_err++; $display("FAIL stall_hold: got v=%b t=%h want v=1 t=%h", wreq.tvalid, wreq.t, held); end
      end
      stalled = wreq.tvalid && !wrsp.tready;
      held    = wreq.t;
      step();
      if (k >= 0) k++;
      if (rsps.size() > 0) break;
    end
    wrsp.tready = 1'b1;
    n_cmp++; if (rsps.size() != 1) begin n_err++; $display("FAIL stall_rsp: got %0d want 1", rsps.size()); end
    n_cmp++; if (pops.size() != 4) begin n_err++; $display("FAIL stall_pops: got %0d want 4", pops.size()); end
    n_cmp++; if (b_data.size() != 4) begin n_err++; $display("FAIL stall_beats: got %0d want 4", b_data.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (b_data[i] !== pop_data[i] || b_last[i] !== (i == 3)) begin
        n_err++; $display("FAIL stall_beat%0d: got %h/%b want %h/%b", i, b_data[i], b_last[i], pop_data[i], i == 3); end
    end
  endtask

  task automatic test_buf_stall();
    logic acc;
    clear_log();
    start(2'd0, 2'd0, 8'd1, acc);
    for (int i = 1; i <= 30; i++) begin
      buf_valid   = (i >= 2 && i <= 4) ? 4'b1011 : 4'b1111;
      wrsp.tready = (i != 2);
      #1;
      if (i >= 2 && i <= 4) begin
        n_cmp++; if (buf_ready !== 4'b0) begin n_err++; $display("FAIL bufstall_ready%0d: got %b want 0000", i, buf_ready); end
      end
      if (i == 2 || i == 3) begin
        n_cmp++; if (wreq.tvalid !== 1'b1) begin n_err++; $display("FAIL bufstall_hold%0d: got %b want 1", i, wreq.tvalid); end
      end
      if (i == 4) begin
        n_cmp++; if (wreq.tvalid !== 1'b0) begin n_err++; $display("FAIL bufstall_drop: got %b want 0", wreq.tvalid); end
      end
      step();
      if (rsps.size() > 0) break;
    end
    buf_valid = 4'hf; wrsp.tready = 1'b1;
    n_cmp++; if (rsps.size() != 1 || pops.size() != 2 || b_last.size() != 2 || b_last[1] !== 1'b1) begin
      n_err++; $display("FAIL bufstall_done: got rsp=%0d pops=%0d beats=%0d want 1/2/2", rsps.size(), pops.size(), b_last.size()); end
  endtask

  task automatic test_rsp_stall();
    logic acc, ok;
    clear_log();
    dp_rsp_ready = 1'b0;
    start(2'd0, 2'd0, 8'd0, acc);
    dp_req = '{offset: 2'd2, tailer: 2'd0, num_beats: 8'd1};
    dp_req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (dp_rsp_valid) begin ok = 1'b1; break; end
      n_cmp++; if (dp_req_ready !== 1'b0) begin n_err++; $display("FAIL rspstall_busy%0d: got %b want 0", i, dp_req_ready); end
      step();
    end
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rspstall_timeout: no response valid within 10 cycles"); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (dp_rsp_valid !== 1'b1 || dp_req_ready !== 1'b0) begin
        n_err++; $display("FAIL rspstall_hold%0d: got v=%b rdy=%b want v=1 rdy=0", i, dp_rsp_valid, dp_req_ready); end
      step();
      #1;
    end
    dp_rsp_ready = 1'b1;
    step();
    #1;
    n_cmp++; if (dp_req_ready !== 1'b1) begin n_err++; $display("FAIL rspstall_next_accept: got %b want 1", dp_req_ready); end
    step();
    dp_req_valid = 1'b0;
    #1;
    n_cmp++; if (buf_ready !== 4'b1100) begin n_err++; $display("FAIL rspstall_next_pop: got %b want 1100", buf_ready); end
    step();
    run_until_rsp(20, ok);
    n_cmp++; if (ok !== 1'b1 || rsps.size() != 2) begin n_err++; $display("FAIL rspstall_second_rsp: got %0d want 2", rsps.size()); end
    n_cmp++; if (b_strb[1] !== 4'b1100 || b_strb[2] !== 4'b1111 || b_last[2] !== 1'b1) begin
      n_err++; $display("FAIL rspstall_second_beats: got %b %b last=%b want 1100 1111 last=1", b_strb[1], b_strb[2], b_last[2]); end
  endtask

  task automatic test_reset_mid();
    logic acc, ok;
    logic [3:0] es[3] = '{4'b1110, 4'b1111, 4'b0111};
    clear_log();
    start(2'd0, 2'd0, 8'd5, acc);
    #1; step();
    #1; step();
    rst = 1'b1;
    #1; step();
    rst = 1'b0;
    #1;
    n_cmp++; if (wreq.tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid: got %b want 0", wreq.tvalid); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want IDLE", dut.state_q); end
    n_cmp++; if (dp_req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_req_ready: got %b want 1", dp_req_ready); end
    n_cmp++; if (buf_ready !== 4'b0) begin n_err++; $display("FAIL midrst_buf_ready: got %b want 0000", buf_ready); end
    clear_log();
    start(2'd1, 2'd3, 8'd2, acc);
    n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL midrst_accept: got %b want 1", acc); end
    run_until_rsp(30, ok);
    n_cmp++; if (ok !== 1'b1 || b_strb.size() != 3) begin n_err++; $display("FAIL midrst_rerun: got ok=%b beats=%0d want 1/3", ok, b_strb.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (b_strb[i] !== es[i] || b_last[i] !== (i == 2) || b_data[i] !== pop_data[i]) begin
        n_err++; $display("FAIL midrst_beat%0d: got strb=%b last=%b want strb=%b last=%b", i, b_strb[i], b_last[i], es[i], i == 2); end
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_single();
    test_tready_stall();
    test_buf_stall();
    test_rsp_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
